// File: rtl/fir_stim_gen_if.sv
// Control and sample-stream bundle between a stimulus controller and fir_stim_gen.
// The master drives the controls and observes the sample stream; the slave is the generator.
interface fir_stim_gen_if #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
);
    logic              ena;
    logic              start;
    logic              stop;
    logic [1:0]        mode;
    logic [DATA_W-1:0] amplitude;
    logic [DIV_W-1:0]  rate_div;
    logic [7:0]        length;
    logic [DATA_W-1:0] sample_out;
    logic              sample_valid;
    logic              busy;
    logic              done;

    modport master (
        output ena, start, stop, mode, amplitude, rate_div, length,
        input  sample_out, sample_valid, busy, done
    );

    modport slave (
        input  ena, start, stop, mode, amplitude, rate_div, length,
        output sample_out, sample_valid, busy, done
    );
endinterface

// File: rtl/fir_stim_gen.sv
// Impulse / step / ramp / LFSR stimulus source for the FIR sample input.
// The first sample is registered on the same edge that accepts start.
module fir_stim_gen #(
    parameter int                 DATA_W    = 8,
    parameter int                 DIV_W     = 8,
    parameter logic [DATA_W-1:0]  LFSR_SEED = 'hA5
) (
    input  logic          clk,
    input  logic          rst_n,
    fir_stim_gen_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [1:0]        mode_l, mode_l_nxt;
    logic [DATA_W-1:0] amp_l, amp_l_nxt;
    logic [DIV_W-1:0]  div_l, div_l_nxt;
    logic [7:0]        len_l, len_l_nxt;
    logic [7:0]        idx, idx_nxt;
    logic [DIV_W-1:0]  div_cnt, div_cnt_nxt;
    logic [DATA_W-1:0] lfsr, lfsr_nxt;
    logic [DATA_W-1:0] ramp_acc, ramp_acc_nxt;
    logic [DATA_W-1:0] sample_r, sample_nxt;
    logic              valid_r, valid_nxt;

    // Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1
    function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] s);
        logic nb;
        nb = s[7] ^ s[5] ^ s[4] ^ s[3];
        return {s[DATA_W-2:0], nb};
    endfunction

    function automatic logic [DATA_W-1:0] first_sample(input logic [1:0] m,
                                                       input logic [DATA_W-1:0] a);
        logic [DATA_W-1:0] v;
        case (m)
            2'd0, 2'd1: v = a;
            2'd2:       v = '0;
            default:    v = LFSR_SEED;
        endcase
        return v;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            mode_l   <= '0;
            amp_l    <= '0;
            div_l    <= '0;
            len_l    <= '0;
            idx      <= '0;
            div_cnt  <= '0;
            lfsr     <= LFSR_SEED;
            ramp_acc <= '0;
            sample_r <= '0;
            valid_r  <= 1'b0;
        end else begin
            state    <= state_nxt;
            mode_l   <= mode_l_nxt;
            amp_l    <= amp_l_nxt;
            div_l    <= div_l_nxt;
            len_l    <= len_l_nxt;
            idx      <= idx_nxt;
            div_cnt  <= div_cnt_nxt;
            lfsr     <= lfsr_nxt;
            ramp_acc <= ramp_acc_nxt;
            sample_r <= sample_nxt;
            valid_r  <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        mode_l_nxt   = mode_l;
        amp_l_nxt    = amp_l;
        div_l_nxt    = div_l;
        len_l_nxt    = len_l;
        idx_nxt      = idx;
        div_cnt_nxt  = div_cnt;
        lfsr_nxt     = lfsr;
        ramp_acc_nxt = ramp_acc;
        sample_nxt   = sample_r;
        valid_nxt    = valid_r;
        if (bus.ena) begin
            valid_nxt = 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start && !bus.stop) begin
                        state_nxt    = S_RUN;
                        mode_l_nxt   = bus.mode;
                        amp_l_nxt    = bus.amplitude;
                        div_l_nxt    = bus.rate_div;
                        len_l_nxt    = bus.length;
                        idx_nxt      = 8'd1;
                        div_cnt_nxt  = '0;
                        lfsr_nxt     = lfsr_step(LFSR_SEED);
                        ramp_acc_nxt = bus.amplitude;
                        sample_nxt   = first_sample(bus.mode, bus.amplitude);
                        valid_nxt    = 1'b1;
                    end
                end
                S_RUN: begin
                    if (bus.stop) begin
                        state_nxt  = S_IDLE;
                        sample_nxt = '0;
                    end else if (len_l != 8'd0 && idx == len_l) begin
                        state_nxt = S_DONE;
                    end else if (div_cnt == div_l) begin
                        // idx counts strobes already emitted; it wraps harmlessly when continuous
                        div_cnt_nxt = '0;
                        idx_nxt     = idx + 8'd1;
                        valid_nxt   = 1'b1;
                        case (mode_l)
                            2'd0: sample_nxt = '0;
                            2'd1: sample_nxt = amp_l;
                            2'd2: begin
                                sample_nxt   = ramp_acc;
                                ramp_acc_nxt = ramp_acc + amp_l;
                            end
                            default: begin
                                sample_nxt = lfsr;
                                lfsr_nxt   = lfsr_step(lfsr);
                            end
                        endcase
                    end else begin
                        div_cnt_nxt = div_cnt + 1'b1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Strobes are held while ena is low so each one is seen for exactly one enabled cycle
    assign bus.sample_out   = sample_r;
    assign bus.sample_valid = valid_r & bus.ena;
    assign bus.busy         = (state == S_RUN);
    assign bus.done         = (state == S_DONE) & bus.ena;
endmodule

// File: tb/tb_fir_stim_gen.sv
// Bench for fir_stim_gen: schedule-based reference model checked every cycle,
// plus literal expectations on the captured strobe stream.
module tb_fir_stim_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fir_stim_gen_if #(.DATA_W(8), .DIV_W(8)) bus();

    fir_stim_gen #(.DATA_W(8), .DIV_W(8), .LFSR_SEED(8'hA5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Value of sample k of a sequence, straight from the waveform definitions
    function automatic logic [7:0] seq_value(input int md, input int amp, input int k);
        int tmp;
        logic [7:0] s;
        case (md)
            0: return (k == 0) ? amp[7:0] : 8'h00;
            1: return amp[7:0];
            2: begin
                tmp = k * amp;
                return tmp[7:0];
            end
            default: begin
                s = 8'hA5;
                for (int i = 0; i < k; i++) s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
                return s;
            end
        endcase
    endfunction

    // Reference: t = enabled cycles since the accepting edge; strobes at multiples of
    // rate+1, done one enabled cycle after the last strobe.
    int         m_st;
    int         m_t, m_mode, m_amp, m_rate, m_len;
    logic [7:0] m_sample;
    logic       m_valid;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st <= 0; m_t <= 0; m_valid <= 1'b0; m_sample <= 8'h00;
            m_mode <= 0; m_amp <= 0; m_rate <= 0; m_len <= 0;
        end else if (bus.ena) begin
            case (m_st)
                0: begin
                    if (bus.start && !bus.stop) begin
                        m_st <= 1; m_t <= 0;
                        m_mode <= int'(bus.mode); m_amp <= int'(bus.amplitude);
                        m_rate <= int'(bus.rate_div); m_len <= int'(bus.length);
                        m_valid <= 1'b1;
                        m_sample <= seq_value(int'(bus.mode), int'(bus.amplitude), 0);
                    end else begin
                        m_valid <= 1'b0;
                    end
                end
                1: begin
                    if (bus.stop) begin
                        m_st <= 0; m_valid <= 1'b0; m_sample <= 8'h00;
                    end else if (m_len != 0 && m_t + 1 == (m_len - 1) * (m_rate + 1) + 1) begin
                        m_st <= 2; m_valid <= 1'b0; m_t <= m_t + 1;
                    end else if ((m_t + 1) % (m_rate + 1) == 0) begin
                        m_valid <= 1'b1; m_t <= m_t + 1;
                        m_sample <= seq_value(m_mode, m_amp, (m_t + 1) / (m_rate + 1));
                    end else begin
                        m_valid <= 1'b0; m_t <= m_t + 1;
                    end
                end
                default: begin
                    m_st <= 0; m_valid <= 1'b0;
                end
            endcase
        end
    end

    logic [7:0] seen[$];
    int         dones = 0;

    always @(negedge clk) begin
        chk("sample_out", int'(bus.sample_out), int'(m_sample));
        chk("sample_valid", int'(bus.sample_valid), int'(m_valid & bus.ena));
        chk("busy", int'(bus.busy), int'(m_st == 1));
        chk("done", int'(bus.done), int'((m_st == 2) & bus.ena));
        if (bus.sample_valid) seen.push_back(bus.sample_out);
        if (bus.done) dones <= dones + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [1:0] md, input logic [7:0] amp,
                      input logic [7:0] rd, input logic [7:0] len);
        bus.mode = md; bus.amplitude = amp; bus.rate_div = rd; bus.length = len;
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        // scramble the controls; the running sequence must not notice
        bus.mode = ~md; bus.amplitude = 8'hFF; bus.rate_div = 8'd7; bus.length = 8'd1;
    endtask

    int base, dbase;

    initial begin
        bus.ena = 1'b1; bus.start = 1'b0; bus.stop = 1'b0;
        bus.mode = 2'd0; bus.amplitude = 8'h00; bus.rate_div = 8'h00; bus.length = 8'h00;
        cyc(3);
        chk("reset_sample", int'(bus.sample_out), 0);
        chk("reset_valid", int'(bus.sample_valid), 0);
        chk("reset_busy", int'(bus.busy), 0);
        rst_n = 1'b1;
        cyc(2);

        base = seen.size(); dbase = dones;
        go(2'd0, 8'h40, 8'd0, 8'd4);
        cyc(10);
        chk("imp_count", seen.size() - base, 4);
        chk("imp_v0", int'(seen[base]), 'h40);
        chk("imp_v1", int'(seen[base+1]), 'h00);
        chk("imp_v3", int'(seen[base+3]), 'h00);
        chk("imp_done", dones - dbase, 1);

        base = seen.size(); dbase = dones;
        go(2'd2, 8'h60, 8'd2, 8'd4);
        cyc(20);
        chk("ramp_count", seen.size() - base, 4);
        chk("ramp_v1", int'(seen[base+1]), 'h60);
        chk("ramp_v2", int'(seen[base+2]), 'hC0);
        chk("ramp_v3", int'(seen[base+3]), 'h20);
        chk("ramp_hold", int'(bus.sample_out), 'h20);
        chk("ramp_done", dones - dbase, 1);

        for (int r = 0; r < 2; r++) begin
            base = seen.size();
            go(2'd3, 8'h00, 8'd0, 8'd4);
            cyc(8);
            chk("lfsr_count", seen.size() - base, 4);
            chk("lfsr_v0", int'(seen[base]), 'hA5);
            chk("lfsr_v1", int'(seen[base+1]), 'h4A);
            chk("lfsr_v2", int'(seen[base+2]), 'h95);
            chk("lfsr_v3", int'(seen[base+3]), 'h2A);
        end

        base = seen.size(); dbase = dones;
        go(2'd1, 8'h7F, 8'd1, 8'd0);
        cyc(50);
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        cyc(60);
        chk("step_ge50", int'(seen.size() - base >= 50), 1);
        for (int i = base; i < seen.size(); i++) chk("step_val", int'(seen[i]), 'h7F);
        chk("step_busy", int'(bus.busy), 1);
        bus.stop = 1'b1;
        cyc(1);
        bus.stop = 1'b0;
        cyc(3);
        chk("stop_sample", int'(bus.sample_out), 0);
        chk("stop_busy", int'(bus.busy), 0);
        chk("stop_no_done", dones - dbase, 0);

        base = seen.size();
        go(2'd2, 8'h11, 8'd0, 8'd0);
        cyc(5);
        bus.ena = 1'b0;
        cyc(5);
        bus.ena = 1'b1;
        cyc(5);
        bus.stop = 1'b1;
        cyc(1);
        bus.stop = 1'b0;
        cyc(2);
        chk("ena_count", seen.size() - base, 11);
        chk("ena_first", int'(seen[base]), 0);
        for (int i = base + 1; i < seen.size(); i++)
            chk("ena_step", int'(seen[i] - seen[i-1]), 'h11);

        go(2'd2, 8'h05, 8'd0, 8'd0);
        cyc(4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sample", int'(bus.sample_out), 0);
        chk("arst_valid", int'(bus.sample_valid), 0);
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_done", int'(bus.done), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(3);
        chk("arst_stay_idle", int'(bus.busy), 0);

        base = seen.size();
        bus.start = 1'b1; bus.stop = 1'b1;
        cyc(1);
        bus.start = 1'b0; bus.stop = 1'b0;
        cyc(3);
        chk("collide_idle", int'(bus.busy), 0);
        chk("collide_nostrobe", seen.size() - base, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
